// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port among two read requesters and one writer,
// with a per-grant burst limit that only bites while another requester is waiting.
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [2:0]        rd_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    last_q, last_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [2:0]    gnt_q, gnt_d;
  logic [2:0]    rdv_q, rdv_d;
  logic          access;
  logic [2:0]    pick_all;
  logic [2:0]    pick_oth;

  function automatic logic [1:0] rr_next(input logic [1:0] id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  // Returns {found, id}: first requester at or after start, wrapping modulo 3.
  function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] start);
    logic [1:0] c0, c1, c2;
    c0 = start;
    c1 = rr_next(c0);
    c2 = rr_next(c1);
    if (r[c0]) return {1'b1, c0};
    if (r[c1]) return {1'b1, c1};
    if (r[c2]) return {1'b1, c2};
    return 3'b000;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] id);
    return 3'b001 << id;
  endfunction

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    burst_d  = burst_q;
    access   = (state_q == OWN) && req[owner_q];
    pick_all = rr_pick(req, rr_next(last_q));
    pick_oth = rr_pick(req & ~onehot(owner_q), rr_next(owner_q));

    case (state_q)
      IDLE: begin
        burst_d = '0;
        if (pick_all[2]) begin
          state_d = OWN;
          owner_d = pick_all[1:0];
          last_d  = pick_all[1:0];
        end
      end
      OWN: begin
        if (!req[owner_q]) begin
          burst_d = '0;
          if (pick_oth[2]) begin
            owner_d = pick_oth[1:0];
            last_d  = pick_oth[1:0];
          end else begin
            state_d = IDLE;
          end
        end else if ((burst_q >= BURST_LAST) && pick_oth[2]) begin
          // This access completes the burst quota and someone is waiting: hand over.
          burst_d = '0;
          owner_d = pick_oth[1:0];
          last_d  = pick_oth[1:0];
        end else if (burst_q != BURST_MAX) begin
          burst_d = burst_q + BW'(1);
        end
      end
      default: ;
    endcase

    gnt_d = (state_d == OWN) ? onehot(owner_d) : 3'b000;
    rdv_d = (access && (owner_q != 2'd2)) ? onehot(owner_q) : 3'b000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      burst_q <= '0;
      gnt_q   <= 3'b000;
      rdv_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      gnt_q   <= gnt_d;
      rdv_q   <= rdv_d;
    end
  end

  // Memory port is driven only while the owner is actually requesting.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    if (access) begin
      case (owner_q)
        2'd0: begin
          mem_addr = addr0;
          mem_rd   = 1'b1;
        end
        2'd1: begin
          mem_addr = addr1;
          mem_rd   = 1'b1;
        end
        2'd2: begin
          mem_addr  = addr2;
          mem_wdata = wdata2;
          mem_wr    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign busy     = |gnt_q;
  assign rd_valid = rdv_q;
  assign rdata    = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle expectations with a read-return scoreboard.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] addr0, addr1, addr2;
  logic [7:0]  wdata2;
  logic [2:0]  gnt;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_rdata;
  logic [2:0]  rd_valid;
  logic [7:0]  rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] rv;
    logic [7:0] rd;
  } exp_t;

  exp_t sb[$];

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .wdata2(wdata2),
    .gnt(gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .rd_valid(rd_valid), .rdata(rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_model(input logic [15:0] a);
    if (a == 16'h0040) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks one cycle of outputs, acts as the memory for reads, then advances a clock.
  task automatic tick(input logic [2:0] eg, input logic erd, input logic ewr,
                      input logic [15:0] ea, input logic [7:0] ewd, input string tag);
    exp_t e;
    #1;
    chk(32'(gnt), 32'(eg), {tag, ".gnt"});
    chk(32'(busy), 32'(|eg), {tag, ".busy"});
    chk(32'(mem_rd), 32'(erd), {tag, ".mem_rd"});
    chk(32'(mem_wr), 32'(ewr), {tag, ".mem_wr"});
    chk(32'(mem_addr), 32'(ea), {tag, ".mem_addr"});
    chk(32'(mem_wdata), 32'(ewd), {tag, ".mem_wdata"});
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
    chk(32'(rd_valid), 32'(e.rv), {tag, ".rd_valid"});
    if (e.rv != 3'b000) chk(32'(rdata), 32'(e.rd), {tag, ".rdata"});
    if (erd) begin
      mem_rdata = mem_model(ea);
      e.rv = eg;
      e.rd = mem_rdata;
      sb.push_back(e);
    end else begin
      mem_rdata = 8'($urandom_range(0, 255));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req       = 3'b000;
    addr0     = 16'h0010;
    addr1     = 16'h0020;
    addr2     = 16'h0030;
    wdata2    = 8'h77;
    mem_rdata = 8'h00;
    @(posedge clk);
    #1;

    // reset holds everything off even with all requests up
    req = 3'b111;
    tick(3'b000, 0, 0, 16'h0, 8'h0, "reset_hold");
    tick(3'b000, 0, 0, 16'h0, 8'h0, "reset_hold2");
    rst = 1'b0;
    tick(3'b000, 0, 0, 16'h0, 8'h0, "grant_latency");
    for (int i = 0; i < 16; i++) tick(3'b001, 1, 0, addr0, 8'h0, "rr_owner0");
    for (int i = 0; i < 16; i++) tick(3'b010, 1, 0, addr1, 8'h0, "rr_owner1");
    for (int i = 0; i < 16; i++) tick(3'b100, 0, 1, addr2, wdata2, "rr_owner2");
    tick(3'b001, 1, 0, addr0, 8'h0, "rr_wrap");
    req = 3'b000;
    tick(3'b001, 0, 0, 16'h0, 8'h0, "release0");
    tick(3'b000, 0, 0, 16'h0, 8'h0, "idle0");

    // single reader 1 with known data
    addr1 = 16'h0040;
    req   = 3'b010;
    tick(3'b000, 0, 0, 16'h0, 8'h0, "single_latency");
    tick(3'b010, 1, 0, 16'h0040, 8'h0, "single_read");
    req = 3'b000;
    tick(3'b010, 0, 0, 16'h0, 8'h0, "single_release");
    tick(3'b000, 0, 0, 16'h0, 8'h0, "idle1");

    // writer wins the round-robin over reader 0, then drops its request
    req    = 3'b101;
    addr2  = 16'h0100;
    wdata2 = 8'h11;
    tick(3'b000, 0, 0, 16'h0, 8'h0, "wr_latency");
    tick(3'b100, 0, 1, 16'h0100, 8'h11, "wr0");
    addr2  = 16'h0101;
    wdata2 = 8'h12;
    tick(3'b100, 0, 1, 16'h0101, 8'h12, "wr1");
    addr2  = 16'h0102;
    wdata2 = 8'h13;
    tick(3'b100, 0, 1, 16'h0102, 8'h13, "wr2");
    req = 3'b001;
    tick(3'b100, 0, 0, 16'h0, 8'h0, "wr_release");
    tick(3'b001, 1, 0, addr0, 8'h0, "after_wr");

    // lone requester keeps the grant well past the burst limit
    for (int i = 0; i < 40; i++) tick(3'b001, 1, 0, addr0, 8'h0, "sat_hold");
    req = 3'b011;
    tick(3'b001, 1, 0, addr0, 8'h0, "sat_handoff");
    tick(3'b010, 1, 0, addr1, 8'h0, "sat_new_owner");
    req = 3'b000;
    tick(3'b010, 0, 0, 16'h0, 8'h0, "sat_release");
    tick(3'b000, 0, 0, 16'h0, 8'h0, "idle2");

    // reset during the 5th read of a burst
    req = 3'b001;
    tick(3'b000, 0, 0, 16'h0, 8'h0, "abort_latency");
    for (int i = 0; i < 4; i++) tick(3'b001, 1, 0, addr0, 8'h0, "abort_reads");
    rst = 1'b1;
    sb.delete();
    tick(3'b000, 0, 0, 16'h0, 8'h0, "abort_reset");
    req = 3'b110;
    tick(3'b000, 0, 0, 16'h0, 8'h0, "abort_hold");
    rst = 1'b0;
    tick(3'b000, 0, 0, 16'h0, 8'h0, "abort_idle");
    tick(3'b010, 1, 0, addr1, 8'h0, "abort_first");
    req = 3'b000;
    tick(3'b010, 0, 0, 16'h0, 8'h0, "abort_release");
    tick(3'b000, 0, 0, 16'h0, 8'h0, "final_idle");

    chk(32'(sb.size()), 32'd0, "sb_empty");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
